// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: serializes one (column, row, character) command as three
// back-to-back 8N1 UART bytes, LSB first: {1'b0,col}, {3'b000,row}, char.
// Out-of-range commands are consumed, flagged with a one-cycle cmd_err
// pulse, and produce no line activity.
module uart_cmd_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int STOP_BITS    = 1,
  parameter int MAX_COL      = 79,
  parameter int MAX_ROW      = 29
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_col,
  input  logic [4:0] cmd_row,
  input  logic [7:0] cmd_char,
  output logic       tx,
  output logic       busy,
  output logic       cmd_err
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_MAX = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   buf_q, buf_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic          baud_tick_s;
  logic          out_of_range_s;

  assign baud_tick_s    = (baud_q == BAUD_MAX);
  assign out_of_range_s = (cmd_col > 7'(MAX_COL)) || (cmd_row > 5'(MAX_ROW));

  // Next-state, counter and buffer logic; tx is derived from the next state
  // so the registered line already shows the new bit in its first cycle.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    err_d      = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      IDLE: begin
        baud_d     = '0;
        bit_idx_d  = 3'd0;
        byte_idx_d = 2'd0;
        busy_d     = 1'b0;
        ready_d    = 1'b1;
        if (cmd_valid && ready_q) begin
          if (out_of_range_s) begin
            err_d = 1'b1;
          end else begin
            // Low byte goes out first; each byte is shifted out LSB first.
            buf_d   = {cmd_char, 3'b000, cmd_row, 1'b0, cmd_col};
            state_d = START;
            busy_d  = 1'b1;
            ready_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (baud_tick_s) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      DATA: begin
        if (baud_tick_s) begin
          baud_d = '0;
          buf_d  = {1'b0, buf_q[23:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      STOP: begin
        // bit_idx counts stop bits here so two stop bits need no extra counter.
        if (baud_tick_s) begin
          baud_d = '0;
          if (bit_idx_q == STOP_MAX) begin
            bit_idx_d = 3'd0;
            if (byte_idx_q == 2'd2) begin
              byte_idx_d = 2'd0;
              state_d    = IDLE;
              busy_d     = 1'b0;
              ready_d    = 1'b1;
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
              state_d    = START;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        baud_d     = '0;
        bit_idx_d  = 3'd0;
        byte_idx_d = 2'd0;
        busy_d     = 1'b0;
        ready_d    = 1'b1;
      end
    endcase

    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = buf_d[0];
    end else begin
      tx_d = 1'b1;
    end
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      buf_q      <= 24'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign cmd_ready = ready_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Testbench for uart_cmd_tx: a default-timing instance (a) and a
// CLKS_PER_BIT=4 / STOP_BITS=2 instance (b). Stimulus is driven and outputs
// are sampled on the falling clock edge.
module tb_uart_cmd_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_a, valid_b;
  logic [6:0] col;
  logic [4:0] row;
  logic [7:0] ch;
  logic       ready_a, tx_a, busy_a, err_a;
  logic       ready_b, tx_b, busy_b, err_b;
  logic       sel_b;
  logic       tx_m, busy_m, ready_m, err_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_cmd_tx dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(valid_a), .cmd_ready(ready_a),
    .cmd_col(col), .cmd_row(row), .cmd_char(ch),
    .tx(tx_a), .busy(busy_a), .cmd_err(err_a)
  );

  uart_cmd_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(valid_b), .cmd_ready(ready_b),
    .cmd_col(col), .cmd_row(row), .cmd_char(ch),
    .tx(tx_b), .busy(busy_b), .cmd_err(err_b)
  );

  assign tx_m    = sel_b ? tx_b    : tx_a;
  assign busy_m  = sel_b ? busy_b  : busy_a;
  assign ready_m = sel_b ? ready_b : ready_a;
  assign err_m   = sel_b ? err_b   : err_a;

  typedef struct {
    logic [6:0] col;
    logic [4:0] row;
    logic [7:0] ch;
    logic       err;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a command for one rising edge; returns at the falling edge of the
  // cycle right after the accept.
  task automatic drive_cmd(input logic [6:0] c, input logic [4:0] r, input logic [7:0] x);
    @(negedge clk);
    col = c; row = r; ch = x;
    if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  // Starting at the first START cycle, check every cycle of the three-byte
  // frame, then the first idle cycle and the total busy length.
  task automatic check_frame(input int cpb, input int sb,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bytes [3];
    logic [7:0] bv;
    logic       exp_bit, act_bit;
    int         busy_cnt;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    busy_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      bv = bytes[k];
      for (int c = 0; c < 9 + sb; c++) begin
        if (c == 0)      exp_bit = 1'b0;
        else if (c <= 8) exp_bit = bv[c-1];
        else             exp_bit = 1'b1;
        act_bit = tx_m;
        for (int cyc = 0; cyc < cpb; cyc++) begin
          if (tx_m !== exp_bit) act_bit = tx_m;
          if (busy_m === 1'b1) busy_cnt++;
          @(negedge clk);
        end
        chk($sformatf("byte%0d_cell%0d", k, c), act_bit, exp_bit);
      end
    end
    chk("busy_len", busy_cnt, 3 * (9 + sb) * cpb);
    chk("end_busy", busy_m, 1'b0);
    chk("end_ready", ready_m, 1'b1);
    chk("end_tx", tx_m, 1'b1);
  endtask

  initial begin
    logic idle_bad;

    vecs[0] = '{7'd17, 5'd29, 8'h32, 1'b0, 8'h11, 8'h1D, 8'h32};
    vecs[1] = '{7'd79, 5'd0,  8'h39, 1'b0, 8'h4F, 8'h00, 8'h39};
    vecs[2] = '{7'd80, 5'd5,  8'h41, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{7'd10, 5'd30, 8'h42, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{7'd0,  5'd0,  8'hA5, 1'b0, 8'h00, 8'h00, 8'hA5};
    vecs[5] = '{7'd127, 5'd31, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00};

    sel_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    col = 7'd0; row = 5'd0; ch = 8'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",    tx_a,    1'b1);
    chk("rst_ready", ready_a, 1'b1);
    chk("rst_busy",  busy_a,  1'b0);
    chk("rst_err",   err_a,   1'b0);
    chk("rst_tx_b",  tx_b,    1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven commands on the default-timing instance.
    for (int i = 0; i < 6; i++) begin
      drive_cmd(vecs[i].col, vecs[i].row, vecs[i].ch);
      if (vecs[i].err) begin
        chk($sformatf("v%0d_err", i),   err_a,   1'b1);
        chk($sformatf("v%0d_ready", i), ready_a, 1'b1);
        chk($sformatf("v%0d_tx", i),    tx_a,    1'b1);
        chk($sformatf("v%0d_busy", i),  busy_a,  1'b0);
        @(negedge clk);
        chk($sformatf("v%0d_err_end", i), err_a, 1'b0);
        chk($sformatf("v%0d_tx2", i),     tx_a,  1'b1);
      end else begin
        chk($sformatf("v%0d_err", i),   err_a,   1'b0);
        chk($sformatf("v%0d_ready", i), ready_a, 1'b0);
        check_frame(217, 1, vecs[i].b0, vecs[i].b1, vecs[i].b2);
      end
    end

    // Reset during the DATA phase of byte1: start cell (217) + byte0 (10
    // cells) puts byte1 data at 2387 cycles; go three bits further in.
    drive_cmd(7'd5, 5'd3, 8'h41);
    repeat (2387 + 3 * 217 + 100) @(negedge clk);
    chk("mid_busy", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_tx",    tx_a,    1'b1);
    chk("async_busy",  busy_a,  1'b0);
    chk("async_ready", ready_a, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_bad = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) idle_bad = 1'b1;
    end
    chk("post_reset_idle", idle_bad, 1'b0);

    // Small-timing instance: held cmd_valid across a frame, new data mid-frame.
    sel_b = 1'b1;
    @(negedge clk);
    col = 7'd33; row = 5'd12; ch = 8'h5A; valid_b = 1'b1;
    @(negedge clk);
    col = 7'd64; row = 5'd7; ch = 8'hC3;
    chk("b2b_ready_low", ready_b, 1'b0);
    check_frame(4, 2, 8'h21, 8'h0C, 8'h5A);
    @(negedge clk);
    valid_b = 1'b0;
    chk("b2b_second_start", busy_b, 1'b1);
    check_frame(4, 2, 8'h40, 8'h07, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
